sdio_bus_arbiter: RTL and testbench
===================================

SDIO_BUS_ARBITER -- requirements
Module: sdio_bus_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, default 4: idle cycles between ownership change, range 1..15.
REQ-002 Parameter WDOG_CYCLES, default 65535: max c_busy cycles without c_done, 16-bit.
REQ-003 clk  in  1  system clock.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 r_req / w_req  in  1  read-side / write-side bus request, level, held for whole tenure.
REQ-006 r_gnt / w_gnt  out  1  grant to read / write side.
REQ-007 r_start / w_start  in  1  per-side command start pulse.
REQ-008 r_cmd / w_cmd  in  6  per-side command index.
REQ-009 r_arg / w_arg  in  32  per-side command argument.
REQ-010 r_clkdiv / w_clkdiv  in  16  per-side sdclk divider.
REQ-011 r_precnt / w_precnt  in  16  per-side pre-command idle count.
REQ-012 c_start, c_cmd, c_arg, c_clkdiv, c_precnt  out  1/6/32/16/16  muxed command-controller inputs.
REQ-013 c_busy, c_done, c_timeout  in  1  command-controller status.
REQ-014 dat_oe  out  1  1 = write side drives dat0, 0 = dat0 high-Z (read side listens).
REQ-015 wdog_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 States: IDLE, GNT_R, GNT_W, DRAIN, TURN; encoding free.
REQ-017 IDLE: at most one grant raised the cycle after a req is sampled high; r_gnt/w_gnt never both 1.
REQ-018 Both req high in IDLE: grant side not last served (round-robin); last_owner resets to write, so read wins first tie.
REQ-019 GNT_x: c_cmd/c_arg/c_clkdiv/c_precnt follow granted side combinationally; c_start = granted side start; other side's start ignored, no queuing.
REQ-020 In IDLE/DRAIN/TURN, c_start = 0 and c_* buses hold last granted values.
REQ-021 dat_oe = 1 only in GNT_W; 0 in all other states, including DRAIN of a write tenure.
REQ-022 Granted req low -> DRAIN; gnt drops that cycle.
REQ-023 DRAIN -> TURN on first cycle c_busy = 0 (immediately if already 0).
REQ-024 TURN lasts exactly TURN_CYCLES cycles, then IDLE; last_owner updated on entry to TURN.
REQ-025 Request arriving in DRAIN/TURN is granted only after IDLE; same side may be regranted after TURN.
REQ-026 c_done/c_timeout only end watchdog count; never change grant.
REQ-027 Req drop and start in same cycle: start not forwarded.

Reset
REQ-028 rstn low: state IDLE, r_gnt = w_gnt = 0, c_start = 0, c_cmd/c_arg/c_clkdiv/c_precnt = 0, dat_oe = 0, wdog_err = 0, last_owner = write, counters = 0.
REQ-029 Reset mid-tenure drops grant and dat_oe asynchronously; no command issued before first post-reset grant.

Configuration
REQ-030 Macro SDIO_ARB_WATCHDOG_EN defined: counter runs while c_busy = 1 in GNT_x/DRAIN, clears on c_done, c_timeout or c_busy = 0; reaching WDOG_CYCLES forces TURN, drops grant, pulses wdog_err once.
REQ-031 Macro absent: no watchdog logic, wdog_err tied 0, DRAIN waits on c_busy indefinitely.

Verification
REQ-032 r_req=1 alone -> r_gnt=1 next cycle; r_start with r_cmd=17, r_arg=0x20 -> c_start=1, c_cmd=17, c_arg=0x20 same cycle, dat_oe=0.
REQ-033 r_req, w_req rise together after reset -> r_gnt first; r_req drops -> w_gnt exactly TURN_CYCLES+1 cycles after DRAIN exits with c_busy=0 (5 at default); dat_oe=1 with w_gnt.
REQ-034 w_start pulse during GNT_R -> c_start stays 0, c_cmd unchanged.
REQ-035 w_req drops while c_busy=1 for 20 cycles -> DRAIN 20 cycles, dat_oe=0 throughout, then 4 TURN cycles, then IDLE.
REQ-036 Macro defined, WDOG_CYCLES=100, c_busy held 1, no c_done -> grant drops, wdog_err=1 for one cycle on cycle 100; without macro, grant held.
REQ-037 rstn low mid-GNT_W -> w_gnt=0, dat_oe=0 immediately; after release, r_req wins tie.

Source files
------------

// File: rtl/sdio_bus_arbiter.sv
// Two-master arbiter sharing one SDIO command controller and dat0 line, with drain/turnaround.
// Optional busy watchdog enabled by defining SDIO_ARB_WATCHDOG_EN.
module sdio_bus_arbiter #(
    parameter int unsigned TURN_CYCLES = 4,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        r_req,
    input  logic        w_req,
    output logic        r_gnt,
    output logic        w_gnt,
    input  logic        r_start,
    input  logic        w_start,
    input  logic [5:0]  r_cmd,
    input  logic [5:0]  w_cmd,
    input  logic [31:0] r_arg,
    input  logic [31:0] w_arg,
    input  logic [15:0] r_clkdiv,
    input  logic [15:0] w_clkdiv,
    input  logic [15:0] r_precnt,
    input  logic [15:0] w_precnt,
    output logic        c_start,
    output logic [5:0]  c_cmd,
    output logic [31:0] c_arg,
    output logic [15:0] c_clkdiv,
    output logic [15:0] c_precnt,
    input  logic        c_busy,
    input  logic        c_done,
    input  logic        c_timeout,
    output logic        dat_oe,
    output logic        wdog_err
);

    typedef enum logic [2:0] {StIdle, StGntR, StGntW, StDrain, StTurn} state_e;

    localparam logic [3:0] TurnLoad = 4'(TURN_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_w_q, last_w_d;   // 1 = write side served last
    logic        owner_w_q, owner_w_d; // side holding (or draining) the bus
    logic [3:0]  turn_cnt_q, turn_cnt_d;
    logic [5:0]  cmd_q, cmd_d;
    logic [31:0] arg_q, arg_d;
    logic [15:0] clkdiv_q, clkdiv_d;
    logic [15:0] precnt_q, precnt_d;
    logic        wdog_err_q, wdog_err_d;
    logic        wdog_abort;

`ifdef SDIO_ARB_WATCHDOG_EN
    localparam logic [15:0] WdogLast = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_active;

    always_comb begin
        wdog_active = ((state_q == StGntR) || (state_q == StGntW) || (state_q == StDrain)) &&
                      c_busy && !c_done && !c_timeout;
        wdog_abort  = wdog_active && (wdog_cnt_q == WdogLast);
        wdog_cnt_d  = (wdog_active && !wdog_abort) ? wdog_cnt_q + 16'd1 : 16'd0;
    end
`else
    logic unused_wdog;
    assign wdog_abort  = 1'b0;
    assign unused_wdog = c_done ^ c_timeout ^ (WDOG_CYCLES == 0);
`endif

    always_comb begin
        state_d    = state_q;
        last_w_d   = last_w_q;
        owner_w_d  = owner_w_q;
        turn_cnt_d = turn_cnt_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        clkdiv_d   = clkdiv_q;
        precnt_d   = precnt_q;
        wdog_err_d = wdog_abort;

        unique case (state_q)
            StIdle: begin
                // Tie goes to the side not served last.
                if (r_req && (!w_req || last_w_q)) begin
                    state_d   = StGntR;
                    owner_w_d = 1'b0;
                end else if (w_req) begin
                    state_d   = StGntW;
                    owner_w_d = 1'b1;
                end
            end
            StGntR, StGntW: begin
                cmd_d    = c_cmd;
                arg_d    = c_arg;
                clkdiv_d = c_clkdiv;
                precnt_d = c_precnt;
                if (wdog_abort) begin
                    state_d    = StTurn;
                    turn_cnt_d = TurnLoad;
                    last_w_d   = owner_w_q;
                end else if ((state_q == StGntR) ? !r_req : !w_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wdog_abort || !c_busy) begin
                    state_d    = StTurn;
                    turn_cnt_d = TurnLoad;
                    last_w_d   = owner_w_q;
                end
            end
            StTurn: begin
                if (turn_cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            last_w_q   <= 1'b1;
            owner_w_q  <= 1'b0;
            turn_cnt_q <= 4'd0;
            cmd_q      <= 6'd0;
            arg_q      <= 32'd0;
            clkdiv_q   <= 16'd0;
            precnt_q   <= 16'd0;
            wdog_err_q <= 1'b0;
`ifdef SDIO_ARB_WATCHDOG_EN
            wdog_cnt_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            last_w_q   <= last_w_d;
            owner_w_q  <= owner_w_d;
            turn_cnt_q <= turn_cnt_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            clkdiv_q   <= clkdiv_d;
            precnt_q   <= precnt_d;
            wdog_err_q <= wdog_err_d;
`ifdef SDIO_ARB_WATCHDOG_EN
            wdog_cnt_q <= wdog_cnt_d;
`endif
        end
    end

    // Grant is withdrawn in the same cycle the owner lowers its request.
    assign r_gnt    = (state_q == StGntR) && r_req;
    assign w_gnt    = (state_q == StGntW) && w_req;
    assign dat_oe   = w_gnt;
    assign c_start  = (r_gnt && r_start) || (w_gnt && w_start);
    assign wdog_err = wdog_err_q;

    always_comb begin
        c_cmd    = cmd_q;
        c_arg    = arg_q;
        c_clkdiv = clkdiv_q;
        c_precnt = precnt_q;
        if (state_q == StGntR) begin
            c_cmd    = r_cmd;
            c_arg    = r_arg;
            c_clkdiv = r_clkdiv;
            c_precnt = r_precnt;
        end else if (state_q == StGntW) begin
            c_cmd    = w_cmd;
            c_arg    = w_arg;
            c_clkdiv = w_clkdiv;
            c_precnt = w_precnt;
        end
    end

endmodule

// File: tb/tb_sdio_bus_arbiter.sv
// Directed bench for sdio_bus_arbiter: vector table plus multi-cycle corner sequences.
module tb_sdio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        r_req = 0, w_req = 0, r_start = 0, w_start = 0;
    logic [5:0]  r_cmd = 0, w_cmd = 0;
    logic [31:0] r_arg = 32'h20, w_arg = 32'h55;
    logic [15:0] r_clkdiv = 16'h10, w_clkdiv = 16'h4;
    logic [15:0] r_precnt = 16'h8, w_precnt = 16'h2;
    logic        c_busy = 0, c_done = 0, c_timeout = 0;
    logic        r_gnt, w_gnt, c_start, dat_oe, wdog_err;
    logic [5:0]  c_cmd;
    logic [31:0] c_arg;
    logic [15:0] c_clkdiv, c_precnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sdio_bus_arbiter #(.TURN_CYCLES(4), .WDOG_CYCLES(100)) dut (
        .clk(clk), .rstn(rstn),
        .r_req(r_req), .w_req(w_req), .r_gnt(r_gnt), .w_gnt(w_gnt),
        .r_start(r_start), .w_start(w_start), .r_cmd(r_cmd), .w_cmd(w_cmd),
        .r_arg(r_arg), .w_arg(w_arg), .r_clkdiv(r_clkdiv), .w_clkdiv(w_clkdiv),
        .r_precnt(r_precnt), .w_precnt(w_precnt),
        .c_start(c_start), .c_cmd(c_cmd), .c_arg(c_arg), .c_clkdiv(c_clkdiv),
        .c_precnt(c_precnt), .c_busy(c_busy), .c_done(c_done), .c_timeout(c_timeout),
        .dat_oe(dat_oe), .wdog_err(wdog_err)
    );

    typedef struct {
        logic       rq, wq, rs, ws;
        logic [5:0] rc, wc;
        logic       busy;
        logic       e_rg, e_wg, e_cs;
        logic [5:0] e_cmd;
        logic       e_oe;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Steps until the chosen grant rises; n is cycles after the starting negedge.
    task automatic wait_gnt(input bit side_w, input int exp_n, input string name);
        int  n = 0;
        logic g = 1'b0;
        do begin
            @(negedge clk); #1;
            n++;
            g = side_w ? w_gnt : r_gnt;
        end while (!g && n < 40);
        chk(name, n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        int n;
        //           rq wq rs ws  rc     wc     bsy  rg wg cs  cmd    oe
        vecs[0]  = '{0, 0, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd0,  0}; // reset idle
        vecs[1]  = '{1, 0, 0, 0, 6'd17, 6'd0, 0,   0, 0, 0, 6'd0,  0};
        vecs[2]  = '{1, 0, 1, 0, 6'd17, 6'd0, 0,   1, 0, 1, 6'd17, 0}; // read start passes
        vecs[3]  = '{1, 0, 0, 1, 6'd17, 6'd5, 0,   1, 0, 0, 6'd17, 0}; // w_start ignored
        vecs[4]  = '{0, 0, 1, 0, 6'd17, 6'd0, 0,   0, 0, 0, 6'd17, 0}; // drop + start
        vecs[5]  = '{0, 0, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd17, 0}; // drain, held cmd
        vecs[6]  = '{1, 0, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd17, 0}; // turn x4
        vecs[7]  = '{1, 0, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd17, 0};
        vecs[8]  = '{1, 0, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd17, 0};
        vecs[9]  = '{1, 0, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd17, 0};
        vecs[10] = '{1, 0, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd17, 0}; // idle
        vecs[11] = '{1, 0, 1, 0, 6'd3,  6'd0, 0,   1, 0, 1, 6'd3,  0}; // same side regrant
        vecs[12] = '{0, 1, 0, 0, 6'd3,  6'd0, 0,   0, 0, 0, 6'd3,  0};
        vecs[13] = '{0, 1, 0, 0, 6'd0,  6'd0, 1,   0, 0, 0, 6'd3,  0}; // drain busy
        vecs[14] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0};
        vecs[15] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0}; // turn x4
        vecs[16] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0};
        vecs[17] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0};
        vecs[18] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0};
        vecs[19] = '{0, 1, 0, 0, 6'd0,  6'd0, 0,   0, 0, 0, 6'd3,  0}; // idle
        vecs[20] = '{0, 1, 0, 1, 6'd0,  6'd9, 0,   0, 1, 1, 6'd9,  1}; // write grant
        vecs[21] = '{1, 1, 1, 0, 6'd0,  6'd9, 0,   0, 1, 0, 6'd9,  1}; // r_start ignored

        repeat (3) @(negedge clk);
        #1;
        chk("reset_wdog_err", {31'd0, wdog_err}, 32'd0);
        chk("reset_c_clkdiv", {16'd0, c_clkdiv}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            r_req = vecs[i].rq; w_req = vecs[i].wq;
            r_start = vecs[i].rs; w_start = vecs[i].ws;
            r_cmd = vecs[i].rc; w_cmd = vecs[i].wc; c_busy = vecs[i].busy;
            #1;
            chk($sformatf("v%0d_r_gnt", i), {31'd0, r_gnt}, {31'd0, vecs[i].e_rg});
            chk($sformatf("v%0d_w_gnt", i), {31'd0, w_gnt}, {31'd0, vecs[i].e_wg});
            chk($sformatf("v%0d_c_start", i), {31'd0, c_start}, {31'd0, vecs[i].e_cs});
            chk($sformatf("v%0d_c_cmd", i), {26'd0, c_cmd}, {26'd0, vecs[i].e_cmd});
            chk($sformatf("v%0d_dat_oe", i), {31'd0, dat_oe}, {31'd0, vecs[i].e_oe});
        end
        chk("v21_c_clkdiv", {16'd0, c_clkdiv}, 32'h4);
        chk("v21_c_precnt", {16'd0, c_precnt}, 32'h2);
        r_start = 0; w_start = 0;

        // Asynchronous reset in the middle of a write tenure, both requests held.
        @(negedge clk); #3;
        rstn = 1'b0; #1;
        chk("rst_w_gnt", {31'd0, w_gnt}, 32'd0);
        chk("rst_dat_oe", {31'd0, dat_oe}, 32'd0);
        chk("rst_c_cmd", {26'd0, c_cmd}, 32'd0);
        chk("rst_c_start", {31'd0, c_start}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_tie_r_gnt", {31'd0, r_gnt}, 32'd1);
        chk("post_rst_tie_w_gnt", {31'd0, w_gnt}, 32'd0);
        chk("post_rst_c_arg", c_arg, 32'h20);

        // Read drops with controller busy; write waits through drain and turnaround.
        @(negedge clk);
        r_req = 0; c_busy = 1; #1;
        chk("drop_r_gnt", {31'd0, r_gnt}, 32'd0);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); #1;
            if (w_gnt !== 1'b0 || r_gnt !== 1'b0 || dat_oe !== 1'b0) bad++;
        end
        chk("drain_r_no_grant", bad, 0);
        @(negedge clk); c_busy = 0;
        // 1 cycle to leave drain + TURN_CYCLES + 1 idle cycle.
        wait_gnt(1'b1, 6, "turn_to_w_gnt");
        chk("w_gnt_dat_oe", {31'd0, dat_oe}, 32'd1);
        chk("w_gnt_c_arg", c_arg, 32'h55);

        // Write drops while busy 20 drain cycles; dat_oe low the whole time.
        @(negedge clk);
        w_req = 0; r_req = 1; c_busy = 1; #1;
        chk("drop_w_dat_oe", {31'd0, dat_oe}, 32'd0);
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); #1;
            if (dat_oe !== 1'b0 || r_gnt !== 1'b0 || w_gnt !== 1'b0) bad++;
        end
        chk("drain_w_dat_oe_low", bad, 0);
        @(negedge clk); c_busy = 0;
        wait_gnt(1'b0, 6, "turn_to_r_gnt");

        // Controller stuck busy under a read grant.
        c_busy = 1;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (wdog_err !== 1'b1 && n < 150);
`ifdef SDIO_ARB_WATCHDOG_EN
        chk("wdog_cycle", n, 100);
        chk("wdog_gnt_dropped", {31'd0, r_gnt}, 32'd0);
        @(negedge clk); #1;
        chk("wdog_err_one_cycle", {31'd0, wdog_err}, 32'd0);
`else
        chk("no_wdog_cycle", n, 150);
        chk("no_wdog_gnt_held", {31'd0, r_gnt}, 32'd1);
`endif
        c_busy = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
